ex_operand_stage: RTL
=====================

EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 Parameter: DATAWIDTH, default 32, width of the operand and PC datapaths.
REQ-002 i_clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 i_rst_n  in  1  asynchronous, active-low reset.
REQ-004 i_id_valid  in  1  ID stage holds a valid instruction.
REQ-005 i_id_instr  in  32  ID instruction (RV32I encoding).
REQ-006 i_id_pc, i_id_rs1_data, i_id_rs2_data  in  DATAWIDTH  ID PC and register-file read data.
REQ-007 i_flush  in  1  squash the instruction in ID (taken branch/jump).
REQ-008 i_mem_rd  in  5  rd of the instruction currently in MEM; i_mem_regwrite  in  1  that instruction writes rd.
REQ-009 o_ex_valid  out  1;  o_ex_instr  out  32;  o_ex_pc, o_ex_rs1_data, o_ex_rs2_data  out  DATAWIDTH  registered EX-stage contents.
REQ-010 o_ex_rd  out  5;  o_ex_regwrite  out  1  registered destination and write enable.
REQ-011 o_fwd_sel_a, o_fwd_sel_b  out  2  registered operand selects: 00 register data, 01 WB result, 10 MEM result; 11 never driven.
REQ-012 o_stall  out  1  combinational; hold PC and IF/ID this cycle.
REQ-013 o_stall_count  out  16  saturating count of load-use bubbles inserted.

Function
REQ-014 Decode (for ID and EX instructions): regwrite = valid and opcode not 0100011/1100011; uses_rs1 = opcode not 0110111/0010111/1101111; uses_rs2 = opcode in {0110011, 0100011, 1100011}; is_load = opcode 0000011.
REQ-015 o_stall = 1 iff o_ex_valid, EX is_load, EX regwrite, o_ex_rd != 0, i_id_valid, i_flush = 0, and (uses_rs1 and rs1 == o_ex_rd, or uses_rs2 and rs2 == o_ex_rd).
REQ-016 Each edge: if i_flush or o_stall or !i_id_valid, load a bubble (valid 0, regwrite 0, rd 0, instr 0x00000013, sels 00; data/PC don't-care); else capture ID fields, rd = instr[11:7], regwrite per REQ-014.
REQ-017 Latency: one cycle ID to EX; selects valid in the same cycle as the captured instruction.
REQ-018 Next o_fwd_sel_a (operand used, rs1 != 0): 10 if current EX valid, regwrite, not load, o_ex_rd == rs1; else 01 if i_mem_regwrite and i_mem_rd == rs1; else 00. o_fwd_sel_b identical on rs2.
REQ-019 Nearer producer (10) wins when both match; unused operand or register x0 yields 00.
REQ-020 Register-file write in WB is write-through; an instruction in WB during ID needs no forwarding.
REQ-021 o_stall_count increments by 1 on each edge where o_stall = 1; holds at 0xFFFF.
REQ-022 i_flush overrides o_stall: bubble inserted, o_stall = 0, counter unchanged.
REQ-023 A stalled ID instruction is re-presented next cycle; after one bubble the load is in MEM and the dependency resolves to 01 with no second stall.

Reset
REQ-024 i_rst_n low asynchronously forces o_ex_valid 0, o_ex_regwrite 0, o_ex_rd 0, o_ex_instr 0x00000013, o_ex_pc/data 0, sels 00, o_stall_count 0.
REQ-025 Release is synchronous to i_clk; first capture occurs on the first rising edge with i_rst_n high.

Verification
REQ-026 add x3,x1,x2 in EX; ID add x4,x3,x5 -> next cycle o_fwd_sel_a = 10, o_fwd_sel_b = 00.
REQ-027 i_mem_rd = 3, i_mem_regwrite = 1, EX unrelated; ID sub x6,x7,x3 -> o_fwd_sel_a = 00, o_fwd_sel_b = 01.
REQ-028 lw x5 in EX; ID add x6,x5,x7 -> o_stall = 1 one cycle, bubble in EX, o_stall_count = 1; next cycle add captured with o_fwd_sel_a = 01.
REQ-029 EX addi x0,x0,1; ID add x1,x0,x0 -> sels 00; lui x8 in ID after x8 producer -> o_fwd_sel_a = 00.
REQ-030 Load-use condition with i_flush = 1 -> o_stall = 0, bubble captured, count unchanged; counter forced to 0xFFFF plus stall -> stays 0xFFFF.
REQ-031 i_rst_n pulsed low mid-stream between edges -> outputs reach reset values immediately, before the next i_clk edge.

Source files
------------

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with forwarding-select generation and load-use hazard detection.
// Selects are computed from the instruction leaving ID so they are ready alongside it in EX.
module ex_operand_stage #(
  parameter int DATAWIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_id_valid,
  input  logic [31:0]          i_id_instr,
  input  logic [DATAWIDTH-1:0] i_id_pc,
  input  logic [DATAWIDTH-1:0] i_id_rs1_data,
  input  logic [DATAWIDTH-1:0] i_id_rs2_data,
  input  logic                 i_flush,
  input  logic [4:0]           i_mem_rd,
  input  logic                 i_mem_regwrite,
  output logic                 o_ex_valid,
  output logic [31:0]          o_ex_instr,
  output logic [DATAWIDTH-1:0] o_ex_pc,
  output logic [DATAWIDTH-1:0] o_ex_rs1_data,
  output logic [DATAWIDTH-1:0] o_ex_rs2_data,
  output logic [4:0]           o_ex_rd,
  output logic                 o_ex_regwrite,
  output logic [1:0]           o_fwd_sel_a,
  output logic [1:0]           o_fwd_sel_b,
  output logic                 o_stall,
  output logic [15:0]          o_stall_count
);

  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_LUI    = 7'b0110111;
  localparam logic [6:0]  OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [1:0]  SEL_REG    = 2'b00;
  localparam logic [1:0]  SEL_WB     = 2'b01;
  localparam logic [1:0]  SEL_MEM    = 2'b10;
  localparam logic [15:0] CNT_MAX    = 16'hFFFF;

  logic                 r_ex_valid;
  logic [31:0]          r_ex_instr;
  logic [DATAWIDTH-1:0] r_ex_pc;
  logic [DATAWIDTH-1:0] r_ex_rs1_data;
  logic [DATAWIDTH-1:0] r_ex_rs2_data;
  logic [4:0]           r_ex_rd;
  logic                 r_ex_regwrite;
  logic [1:0]           r_fwd_sel_a;
  logic [1:0]           r_fwd_sel_b;
  logic [15:0]          r_stall_count;

  logic [6:0] w_id_opcode;
  logic [4:0] w_id_rs1;
  logic [4:0] w_id_rs2;
  logic [4:0] w_id_rd;
  logic       w_id_regwrite;
  logic       w_id_uses_rs1;
  logic       w_id_uses_rs2;
  logic       w_ex_is_load;
  logic       w_ex_fwd_ok;
  logic       w_load_use;
  logic       w_stall;
  logic       w_bubble;
  logic [1:0] w_sel_a_next;
  logic [1:0] w_sel_b_next;

  assign w_id_opcode = i_id_instr[6:0];
  assign w_id_rd     = i_id_instr[11:7];
  assign w_id_rs1    = i_id_instr[19:15];
  assign w_id_rs2    = i_id_instr[24:20];

  assign w_id_regwrite = i_id_valid && (w_id_opcode != OPC_STORE) && (w_id_opcode != OPC_BRANCH);
  assign w_id_uses_rs1 = (w_id_opcode != OPC_LUI) && (w_id_opcode != OPC_AUIPC) && (w_id_opcode != OPC_JAL);
  assign w_id_uses_rs2 = (w_id_opcode == OPC_OP) || (w_id_opcode == OPC_STORE) || (w_id_opcode == OPC_BRANCH);

  assign w_ex_is_load = (r_ex_instr[6:0] == OPC_LOAD);
  // A load's data only exists after MEM, so EX-to-EX forwarding is limited to non-loads.
  assign w_ex_fwd_ok  = r_ex_valid && r_ex_regwrite && !w_ex_is_load;

  assign w_load_use = (w_id_uses_rs1 && (w_id_rs1 == r_ex_rd)) ||
                      (w_id_uses_rs2 && (w_id_rs2 == r_ex_rd));
  assign w_stall    = r_ex_valid && w_ex_is_load && r_ex_regwrite && (r_ex_rd != 5'd0) &&
                      i_id_valid && !i_flush && w_load_use;
  assign w_bubble   = i_flush || w_stall || !i_id_valid;

  function automatic logic [1:0] pick_sel(
    input logic       used,
    input logic [4:0] rs,
    input logic       ex_ok,
    input logic [4:0] ex_rd,
    input logic       mem_wr,
    input logic [4:0] mem_rd
  );
    logic [1:0] sel;
    sel = SEL_REG;
    if (used && (rs != 5'd0)) begin
      if (ex_ok && (ex_rd == rs)) begin
        sel = SEL_MEM;
      end else if (mem_wr && (mem_rd == rs)) begin
        sel = SEL_WB;
      end
    end
    return sel;
  endfunction

  always_comb begin
    w_sel_a_next = pick_sel(w_id_uses_rs1, w_id_rs1, w_ex_fwd_ok, r_ex_rd, i_mem_regwrite, i_mem_rd);
    w_sel_b_next = pick_sel(w_id_uses_rs2, w_id_rs2, w_ex_fwd_ok, r_ex_rd, i_mem_regwrite, i_mem_rd);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ex_valid    <= 1'b0;
      r_ex_instr    <= NOP_INSTR;
      r_ex_pc       <= '0;
      r_ex_rs1_data <= '0;
      r_ex_rs2_data <= '0;
      r_ex_rd       <= 5'd0;
      r_ex_regwrite <= 1'b0;
      r_fwd_sel_a   <= SEL_REG;
      r_fwd_sel_b   <= SEL_REG;
    end else begin
      // PC and operand data are meaningless in a bubble, so they are captured unconditionally.
      r_ex_pc       <= i_id_pc;
      r_ex_rs1_data <= i_id_rs1_data;
      r_ex_rs2_data <= i_id_rs2_data;
      if (w_bubble) begin
        r_ex_valid    <= 1'b0;
        r_ex_instr    <= NOP_INSTR;
        r_ex_rd       <= 5'd0;
        r_ex_regwrite <= 1'b0;
        r_fwd_sel_a   <= SEL_REG;
        r_fwd_sel_b   <= SEL_REG;
      end else begin
        r_ex_valid    <= 1'b1;
        r_ex_instr    <= i_id_instr;
        r_ex_rd       <= w_id_rd;
        r_ex_regwrite <= w_id_regwrite;
        r_fwd_sel_a   <= w_sel_a_next;
        r_fwd_sel_b   <= w_sel_b_next;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_count <= 16'd0;
    end else if (w_stall && (r_stall_count != CNT_MAX)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign o_ex_valid    = r_ex_valid;
  assign o_ex_instr    = r_ex_instr;
  assign o_ex_pc       = r_ex_pc;
  assign o_ex_rs1_data = r_ex_rs1_data;
  assign o_ex_rs2_data = r_ex_rs2_data;
  assign o_ex_rd       = r_ex_rd;
  assign o_ex_regwrite = r_ex_regwrite;
  assign o_fwd_sel_a   = r_fwd_sel_a;
  assign o_fwd_sel_b   = r_fwd_sel_b;
  assign o_stall       = w_stall;
  assign o_stall_count = r_stall_count;

endmodule
